sparse_tree_writer: RTL and testbench

SPARSE_TREE_WRITER -- requirements
Module: sparse_tree_writer

---
 rtl/sparse_tree_writer.sv | 197 +++++++++++++++++++
 tb/tb_sparse_tree_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_tree_writer.sv
// Sorted sparse-entry store keyed by {row,col}: a serial search locates the slot,
// then a single commit edge overwrites, deletes (shift down) or inserts (shift up).
module sparse_tree_writer #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_row,
  input  logic [W-1:0]       in_col,
  input  logic [W-1:0]       in_data,
  output logic [DEPTH*W-1:0] tree_row,
  output logic [DEPTH*W-1:0] tree_col,
  output logic [DEPTH*W-1:0] tree_data,
  output logic [3:0]         count,
  output logic               full,
  output logic               overflow
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {StIdle, StSearch, StCommit} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   row_q [DEPTH];
  logic [W-1:0]   row_d [DEPTH];
  logic [W-1:0]   col_q [DEPTH];
  logic [W-1:0]   col_d [DEPTH];
  logic [W-1:0]   dat_q [DEPTH];
  logic [W-1:0]   dat_d [DEPTH];
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           ovf_q, ovf_d;
  logic           hit_q, hit_d;
  logic [W-1:0]   lrow_q, lrow_d, lcol_q, lcol_d, ldat_q, ldat_d;
  logic [2*W-1:0] lkey, cur_key;

  // Neighbour indices clamped in range; the clamped cases are never selected.
  function automatic int unsigned nxt(input int unsigned i);
    return (i < DEPTH - 1) ? i + 1 : i;
  endfunction

  function automatic int unsigned prv(input int unsigned i);
    return (i > 0) ? i - 1 : 0;
  endfunction

  assign lkey = {lrow_q, lcol_q};

  always_comb begin
    cur_key = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == CW'(i)) cur_key = {row_q[i], col_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    lrow_d  = lrow_q;
    lcol_d  = lcol_q;
    ldat_d  = ldat_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      row_d[i] = row_q[i];
      col_d[i] = col_q[i];
      dat_d[i] = dat_q[i];
    end

    if (clear) begin
      state_d = StIdle;
      idx_d   = '0;
      hit_d   = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        row_d[i] = '0;
        col_d[i] = '0;
        dat_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            lrow_d  = in_row;
            lcol_d  = in_col;
            ldat_d  = in_data;
            idx_d   = '0;
            state_d = StSearch;
          end
        end
        StSearch: begin
          if (idx_q == count_q || cur_key >= lkey) begin
            hit_d   = (idx_q != count_q) && (cur_key == lkey);
            state_d = StCommit;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StCommit: begin
          state_d = StIdle;
          if (hit_q) begin
            if (ldat_q != '0) begin
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == idx_q) dat_d[i] = ldat_q;
              end
            end else begin
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) >= idx_q && CW'(i) + 1'b1 < count_q) begin
                  row_d[i] = row_q[nxt(i)];
                  col_d[i] = col_q[nxt(i)];
                  dat_d[i] = dat_q[nxt(i)];
                end else if (CW'(i) + 1'b1 == count_q) begin
                  row_d[i] = '0;
                  col_d[i] = '0;
                  dat_d[i] = '0;
                end
              end
              count_d = count_q - 1'b1;
            end
          end else if (ldat_q != '0) begin
            if (count_q == CW'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == idx_q) begin
                  row_d[i] = lrow_q;
                  col_d[i] = lcol_q;
                  dat_d[i] = ldat_q;
                end else if (CW'(i) > idx_q && CW'(i) <= count_q) begin
                  row_d[i] = row_q[prv(i)];
                  col_d[i] = col_q[prv(i)];
                  dat_d[i] = dat_q[prv(i)];
                end
              end
              count_d = count_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      lrow_q  <= '0;
      lcol_q  <= '0;
      ldat_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      lrow_q  <= lrow_d;
      lcol_q  <= lcol_d;
      ldat_q  <= ldat_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        row_q[i] <= row_d[i];
        col_q[i] <= col_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_comb begin
    tree_row  = '0;
    tree_col  = '0;
    tree_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tree_row[W*i +: W]  = row_q[i];
      tree_col[W*i +: W]  = col_q[i];
      tree_data[W*i +: W] = dat_q[i];
    end
  end

  assign in_ready = (state_q == StIdle);
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sparse_tree_writer.sv
// Randomized bench for sparse_tree_writer against a sorted-queue reference model.
module tb_sparse_tree_writer;
  localparam int DEPTH = 15;
  localparam int W     = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_row = '0, in_col = '0, in_data = '0;
  logic [DEPTH*W-1:0] tree_row, tree_col, tree_data;
  logic [3:0]         count;
  logic               full, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: keys and data kept sorted ascending in queues.
  logic [2*W-1:0] kq[$];
  logic [W-1:0]   dq[$];
  bit             movf = 0;

  sparse_tree_writer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .tree_row(tree_row), .tree_col(tree_col), .tree_data(tree_data),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    dq.delete();
    movf = 0;
  endtask

  task automatic model_apply(input logic [W-1:0] r, c, d, output int pos);
    logic [2*W-1:0] key;
    key = {r, c};
    pos = kq.size();
    for (int i = 0; i < kq.size(); i++) begin
      if (kq[i] >= key) begin
        pos = i;
        break;
      end
    end
    if (pos < kq.size() && kq[pos] == key) begin
      if (d != '0) dq[pos] = d;
      else begin
        kq.delete(pos);
        dq.delete(pos);
      end
    end else if (d != '0) begin
      if (kq.size() == DEPTH) movf = 1;
      else begin
        kq.insert(pos, key);
        dq.insert(pos, d);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [DEPTH*W-1:0] er, ec, ed;
    er = '0;
    ec = '0;
    ed = '0;
    for (int i = 0; i < kq.size(); i++) begin
      er[W*i +: W] = kq[i][2*W-1:W];
      ec[W*i +: W] = kq[i][W-1:0];
      ed[W*i +: W] = dq[i];
    end
    check({tag, ".row"}, 256'(tree_row), 256'(er));
    check({tag, ".col"}, 256'(tree_col), 256'(ec));
    check({tag, ".data"}, 256'(tree_data), 256'(ed));
    check({tag, ".count"}, 256'(count), 256'(kq.size()));
    check({tag, ".full"}, 256'(full), 256'(kq.size() == DEPTH));
    check({tag, ".ovf"}, 256'(overflow), 256'(movf));
    check({tag, ".ready"}, 256'(in_ready), 256'(1));
  endtask

  task automatic write_entry(input logic [W-1:0] r, c, d);
    int pos, n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    model_apply(r, c, d, pos);
    in_valid = 1'b1;
    in_row   = r;
    in_col   = c;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_row   = W'($urandom);
    in_col   = W'($urandom);
    in_data  = W'($urandom);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_low_cycles", 256'(n), 256'(pos + 2));
    check_all("post_write");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    check_all("clear");
  endtask

  initial begin
    int pos;
    #2;
    check_all("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic ordered insert, first accept on the edge right after reset release.
    write_entry(2, 3, 7);
    write_entry(0, 5, 9);
    write_entry(2, 1, 4);
    check("r28.slot0", 256'(tree_data[15:0]), 256'(9));
    check("r28.slot2key", 256'({tree_row[47:32], tree_col[47:32]}), 256'({16'd2, 16'd3}));

    // Overwrite then delete.
    write_entry(2, 1, 16'h00AA);
    write_entry(0, 5, 0);
    check("r29.count", 256'(count), 256'(2));
    check("r29.slot0", 256'(tree_data[15:0]), 256'(16'h00AA));

    // Fill, overflow, then overwrite while full.
    do_clear();
    for (int i = 0; i < DEPTH; i++) write_entry(0, W'(i), 1);
    write_entry(1, 0, 5);
    check("r30.ovf", 256'(overflow), 256'(1));
    write_entry(0, 3, 8);
    check("r30.slot3", 256'(tree_data[63:48]), 256'(8));
    check("r30.ovf_sticky", 256'(overflow), 256'(1));

    // Clear overrides a simultaneous handshake.
    clear    = 1'b1;
    in_valid = 1'b1;
    in_row   = 3;
    in_col   = 3;
    in_data  = 3;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check_all("r31");
    @(posedge clk);
    #1;
    check_all("r31_settle");

    // Reset during the search of a fourth insert.
    write_entry(1, 1, 1);
    write_entry(1, 2, 2);
    write_entry(1, 3, 3);
    in_valid = 1'b1;
    in_row   = 16'hFFFF;
    in_col   = 16'hFFFF;
    in_data  = 16'h1234;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("r32.searching", 256'(in_ready), 256'(0));
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    model_reset();
    check_all("r32.in_reset");
    @(posedge clk);
    #1;
    check_all("r32.held");
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_all("r32.released");

    // New key with zero data on an empty tree.
    write_entry(9, 9, 0);

    // Randomized traffic over a small key space so hits, deletes and overflow all occur.
    for (int t = 0; t < 300; t++) begin
      logic [W-1:0] r, c, d;
      if ($urandom_range(0, 39) == 0) do_clear();
      r = W'($urandom_range(0, 3));
      c = W'($urandom_range(0, 5));
      d = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 65535));
      write_entry(r, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
